// File: rtl/mem_preload_pkg.sv
// Shared definitions for the memory preload sequencer: command bytes,
// header length and the controller state encoding.
package mem_preload_pkg;
  localparam logic [7:0] CMD_LOAD_ICCM = 8'h01;
  localparam logic [7:0] CMD_LOAD_DCCM = 8'h02;
  localparam logic [7:0] CMD_FINISH    = 8'h03;

  // Load header: 2 address bytes followed by 2 word-count bytes.
  localparam int HDR_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_WRITE,
    ST_DONE
  } state_e;
endpackage

// File: rtl/top_pkg.sv
// Top-level SoC package: bus data width shared by memory-facing blocks.
package top_pkg;
  localparam int TL_DW = 32;
endpackage

// File: rtl/mem_preload_ctrl_byte_packer.sv
// byte_packer: collects little-endian bytes into a TL_DW word.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   byte_valid_i    a byte is consumed this cycle
//   byte_i          the byte
//   word_valid_o    combinational: high with the 4th byte of a word
//   word_o          assembled word (first byte in bits 7:0), valid with word_valid_o
module byte_packer (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       byte_valid_i,
  input  logic [7:0]                 byte_i,
  output logic                       word_valid_o,
  output logic [top_pkg::TL_DW-1:0]  word_o
);
  localparam int SW = top_pkg::TL_DW - 8;

  logic [1:0]    cnt_q, cnt_d;
  logic [SW-1:0] shift_q, shift_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (byte_valid_i) begin
      cnt_d   = cnt_q + 2'd1;
      // Newest byte enters at the top so the oldest ends up in bits 7:0.
      shift_d = {byte_i, shift_q[SW-1:8]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= 2'd0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);
  assign word_o       = {byte_i, shift_q};
endmodule

// File: rtl/mem_preload_ctrl.sv
// mem_preload_ctrl: parses a byte command stream and writes ICCM/DCCM words
// through the core preload port, holding the core in reset until finish.
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   byte_valid_i/byte_i         input byte stream
//   byte_ready_o                byte accepted when valid && ready
//   iccm_we_o/dccm_we_o         one-cycle write strobes
//   mem_wdata_o/mem_wmask_o     write data / mask (mask all ones only on a strobe)
//   mem_waddr_o                 word address
//   mem_finish_o, core_rst_no   preload done (sticky), core reset release
//   err_o                       sticky: unknown command byte seen
module mem_preload_ctrl
  import mem_preload_pkg::*;
#(
  parameter int AW = 11,
  parameter int CW = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      byte_valid_i,
  input  logic [7:0]                byte_i,
  output logic                      byte_ready_o,
  output logic                      iccm_we_o,
  output logic                      dccm_we_o,
  output logic [top_pkg::TL_DW-1:0] mem_wdata_o,
  output logic [top_pkg::TL_DW-1:0] mem_wmask_o,
  output logic [AW-1:0]             mem_waddr_o,
  output logic                      mem_finish_o,
  output logic                      core_rst_no,
  output logic                      err_o
);
  localparam int DW = top_pkg::TL_DW;

  state_e        state_q, state_d;
  logic [1:0]    hdr_cnt_q, hdr_cnt_d;
  logic [23:0]   hdr_q, hdr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] words_q, words_d;
  logic          dccm_sel_q, dccm_sel_d;
  logic          iccm_we_q, iccm_we_d, dccm_we_q, dccm_we_d;
  logic [DW-1:0] wdata_q, wdata_d, wmask_q, wmask_d;
  logic          finish_q, finish_d, err_q, err_d;

  logic          accept;
  logic          word_valid;
  logic [DW-1:0] word;
  logic [31:0]   hdr_word;
  logic          unused_hdr;

  // State is IDLE during reset, so gate ready with rst_ni to keep it low.
  assign byte_ready_o = rst_ni &&
                        (state_q == ST_IDLE || state_q == ST_HDR || state_q == ST_DATA);
  assign accept       = byte_valid_i && byte_ready_o;
  // Full header as it looks when its last byte arrives.
  assign hdr_word     = {byte_i, hdr_q};
  assign unused_hdr   = ^hdr_word;

  byte_packer u_packer (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .byte_valid_i (accept && (state_q == ST_DATA)),
    .byte_i       (byte_i),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    hdr_d      = hdr_q;
    addr_d     = addr_q;
    words_d    = words_q;
    dccm_sel_d = dccm_sel_q;
    iccm_we_d  = 1'b0;
    dccm_we_d  = 1'b0;
    wdata_d    = wdata_q;
    wmask_d    = '0;
    finish_d   = finish_q;
    err_d      = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (byte_i == CMD_LOAD_ICCM || byte_i == CMD_LOAD_DCCM) begin
            dccm_sel_d = (byte_i == CMD_LOAD_DCCM);
            hdr_cnt_d  = 2'd0;
            state_d    = ST_HDR;
          end else if (byte_i == CMD_FINISH) begin
            finish_d = 1'b1;
            state_d  = ST_DONE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_HDR: begin
        if (accept) begin
          hdr_d     = {byte_i, hdr_q[23:8]};
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'(HDR_BYTES - 1)) begin
            addr_d  = hdr_word[AW-1:0];
            words_d = hdr_word[16 +: CW];
            state_d = (hdr_word[16 +: CW] == '0) ? ST_IDLE : ST_DATA;
          end
        end
      end
      ST_DATA: begin
        // Strobe, data and mask are registered so they all appear together.
        if (word_valid) begin
          wdata_d   = word;
          wmask_d   = '1;
          iccm_we_d = !dccm_sel_q;
          dccm_we_d = dccm_sel_q;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        addr_d  = addr_q + 1'b1;  // wraps at the top of the AW-bit space
        words_d = words_q - 1'b1;
        state_d = (words_q == CW'(1)) ? ST_IDLE : ST_DATA;
      end
      ST_DONE: begin
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      hdr_cnt_q  <= 2'd0;
      hdr_q      <= '0;
      addr_q     <= '0;
      words_q    <= '0;
      dccm_sel_q <= 1'b0;
      iccm_we_q  <= 1'b0;
      dccm_we_q  <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      finish_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_cnt_q  <= hdr_cnt_d;
      hdr_q      <= hdr_d;
      addr_q     <= addr_d;
      words_q    <= words_d;
      dccm_sel_q <= dccm_sel_d;
      iccm_we_q  <= iccm_we_d;
      dccm_we_q  <= dccm_we_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      finish_q   <= finish_d;
      err_q      <= err_d;
    end
  end

  assign iccm_we_o    = iccm_we_q;
  assign dccm_we_o    = dccm_we_q;
  assign mem_wdata_o  = wdata_q;
  assign mem_wmask_o  = wmask_q;
  assign mem_waddr_o  = addr_q;
  assign mem_finish_o = finish_q;
  assign core_rst_no  = finish_q;
  assign err_o        = err_q;
endmodule

// File: tb/tb_mem_preload_ctrl.sv
// Self-checking bench for mem_preload_ctrl: table vectors, hand-written
// multi-cycle sequences and randomized streams against a stream-level model.
module tb_mem_preload_ctrl;
  localparam int AW = 11;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          byte_valid_i = 1'b0;
  logic [7:0]    byte_i = 8'h00;
  logic          byte_ready_o, iccm_we_o, dccm_we_o;
  logic [31:0]   mem_wdata_o, mem_wmask_o;
  logic [AW-1:0] mem_waddr_o;
  logic          mem_finish_o, core_rst_no, err_o;

  always #5 clk = ~clk;

  mem_preload_ctrl #(.AW(AW), .CW(CW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .byte_valid_i (byte_valid_i),
    .byte_i       (byte_i),
    .byte_ready_o (byte_ready_o),
    .iccm_we_o    (iccm_we_o),
    .dccm_we_o    (dccm_we_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_wmask_o  (mem_wmask_o),
    .mem_waddr_o  (mem_waddr_o),
    .mem_finish_o (mem_finish_o),
    .core_rst_no  (core_rst_no),
    .err_o        (err_o)
  );

  typedef struct {
    logic        dccm;
    int          addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [127:0] s;      // stream, right-aligned: last byte in bits 7:0
    int           len;
    int           n_wr;
    logic         dccm;
    logic [10:0]  a0;
    logic [31:0]  d0;
    logic [10:0]  a_last;
    logic         err;
    logic         fin;
  } vec_t;

  wr_t        obs_q[$];
  wr_t        exp_q[$];
  logic [7:0] stim_q[$];
  logic       exp_err, exp_fin;
  int         n_cmp = 0;
  int         n_mis = 0;
  vec_t       vec[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and record any write strobe.
  task automatic tick();
    wr_t w;
    @(negedge clk);
    if (iccm_we_o || dccm_we_o) begin
      chk("single_strobe", 32'(iccm_we_o & dccm_we_o), 32'd0);
      chk("wmask_on", mem_wmask_o, 32'hFFFF_FFFF);
      w.dccm = dccm_we_o;
      w.addr = int'(mem_waddr_o);
      w.data = mem_wdata_o;
      obs_q.push_back(w);
      $display("write %s addr=0x%03h data=0x%08h", dccm_we_o ? "DCCM" : "ICCM",
               mem_waddr_o, mem_wdata_o);
    end else begin
      chk("wmask_off", mem_wmask_o, 32'd0);
    end
  endtask

  task automatic do_reset();
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_ready", 32'(byte_ready_o), 0);
    chk("rst_iccm_we", 32'(iccm_we_o), 0);
    chk("rst_dccm_we", 32'(dccm_we_o), 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_wmask", mem_wmask_o, 0);
    chk("rst_waddr", 32'(mem_waddr_o), 0);
    chk("rst_finish", 32'(mem_finish_o), 0);
    chk("rst_core_rst_n", 32'(core_rst_no), 0);
    chk("rst_err", 32'(err_o), 0);
    byte_valid_i = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    chk("post_rst_ready", 32'(byte_ready_o), 1);
    obs_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit done;
    done = 1'b0;
    byte_valid_i = 1'b0;
    repeat (gap) tick();
    byte_valid_i = 1'b1;
    byte_i = b;
    for (int k = 0; k < 100 && !done; k++) begin
      if (byte_ready_o) done = 1'b1;
      tick();
    end
    byte_valid_i = 1'b0;
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_stream(input int max_gap);
    for (int i = 0; i < stim_q.size(); i++)
      send_byte(stim_q[i], int'($urandom_range(0, max_gap)));
    repeat (3) tick();
  endtask

  // Stream-level reference: walks the byte list as the command language defines it.
  task automatic model();
    int         i, n, addr, cnt;
    logic [7:0] b;
    wr_t        w;
    exp_q.delete();
    exp_err = 1'b0;
    exp_fin = 1'b0;
    i = 0;
    n = stim_q.size();
    while (i < n && !exp_fin) begin
      b = stim_q[i];
      i++;
      if (b == 8'h01 || b == 8'h02) begin
        if (i + 4 > n) break;
        addr = (int'(stim_q[i]) + 256 * int'(stim_q[i+1])) % 2048;
        cnt  = int'(stim_q[i+2]) + 256 * int'(stim_q[i+3]);
        i += 4;
        for (int k = 0; k < cnt && i + 4 <= n; k++) begin
          w.dccm = (b == 8'h02);
          w.addr = addr;
          w.data = {stim_q[i+3], stim_q[i+2], stim_q[i+1], stim_q[i]};
          exp_q.push_back(w);
          addr = (addr + 1) % 2048;
          i += 4;
        end
      end else if (b == 8'h03) begin
        exp_fin = 1'b1;
      end else begin
        exp_err = 1'b1;
      end
    end
  endtask

  task automatic compare_model();
    chk("rnd_count", obs_q.size(), exp_q.size());
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      chk("rnd_target", 32'(obs_q[k].dccm), 32'(exp_q[k].dccm));
      chk("rnd_addr", obs_q[k].addr, exp_q[k].addr);
      chk("rnd_data", obs_q[k].data, exp_q[k].data);
    end
    chk("rnd_err", 32'(err_o), 32'(exp_err));
    chk("rnd_finish", 32'(mem_finish_o), 32'(exp_fin));
  endtask

  initial begin
    logic [7:0] seq[$];
    int         nl, cnt;
    logic [15:0] a16;

    vec[0] = '{128'h0110000200EFBEADDE78563412, 13, 2, 1'b0, 11'h010, 32'hDEADBEEF, 11'h011, 1'b0, 1'b0};
    vec[1] = '{128'h02FF0702001122334455667788, 13, 2, 1'b1, 11'h7FF, 32'h44332211, 11'h000, 1'b0, 1'b0};
    vec[2] = '{128'h550105000100AABBCCDD,       10, 1, 1'b0, 11'h005, 32'hDDCCBBAA, 11'h005, 1'b1, 1'b0};
    vec[3] = '{128'h010000000003,                6, 0, 1'b0, 11'h000, 32'h0,        11'h000, 1'b0, 1'b1};
    vec[4] = '{128'h0234F2010001020304,          9, 1, 1'b1, 11'h234, 32'h04030201, 11'h234, 1'b0, 1'b0};

    @(negedge clk);
    for (int v = 0; v < 5; v++) begin
      do_reset();
      stim_q.delete();
      for (int k = 0; k < vec[v].len; k++)
        stim_q.push_back(vec[v].s[8*(vec[v].len-1-k) +: 8]);
      send_stream(1);
      chk("vec_count", obs_q.size(), vec[v].n_wr);
      if (obs_q.size() > 0 && vec[v].n_wr > 0) begin
        chk("vec_target", 32'(obs_q[0].dccm), 32'(vec[v].dccm));
        chk("vec_addr0", obs_q[0].addr, 32'(vec[v].a0));
        chk("vec_data0", obs_q[0].data, vec[v].d0);
        chk("vec_addr_last", obs_q[obs_q.size()-1].addr, 32'(vec[v].a_last));
      end
      chk("vec_err", 32'(err_o), 32'(vec[v].err));
      chk("vec_finish", 32'(mem_finish_o), 32'(vec[v].fin));
    end

    // Finish timing and terminal DONE behaviour.
    do_reset();
    chk("fin_before", 32'(mem_finish_o), 0);
    chk("core_rst_before", 32'(core_rst_no), 0);
    send_byte(8'h03, 0);
    chk("fin_after", 32'(mem_finish_o), 1);
    chk("core_rst_after", 32'(core_rst_no), 1);
    byte_valid_i = 1'b1;
    byte_i = 8'h01;
    for (int k = 0; k < 6; k++) begin
      chk("done_ready", 32'(byte_ready_o), 0);
      tick();
    end
    byte_valid_i = 1'b0;
    chk("done_no_writes", obs_q.size(), 0);
    chk("done_fin_sticky", 32'(mem_finish_o), 1);

    // 20-cycle stall between bytes 2 and 3 of a data word.
    do_reset();
    seq = '{8'h01, 8'h20, 8'h00, 8'h01, 8'h00, 8'hA1, 8'hB2};
    foreach (seq[k]) send_byte(seq[k], 0);
    send_byte(8'hC3, 20);
    chk("gap_no_early_write", obs_q.size(), 0);
    send_byte(8'hD4, 0);
    repeat (4) tick();
    chk("gap_count", obs_q.size(), 1);
    if (obs_q.size() == 1) begin
      chk("gap_addr", obs_q[0].addr, 32'h020);
      chk("gap_data", obs_q[0].data, 32'hD4C3B2A1);
      chk("gap_target", 32'(obs_q[0].dccm), 0);
    end

    // Reset in the middle of a word, then a fresh load.
    do_reset();
    seq = '{8'h02, 8'h00, 8'h01, 8'h01, 8'h00, 8'hAA, 8'hBB};
    foreach (seq[k]) send_byte(seq[k], 0);
    repeat (2) tick();
    chk("midrst_no_write", obs_q.size(), 0);
    do_reset();
    seq = '{8'h01, 8'h40, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    foreach (seq[k]) send_byte(seq[k], 0);
    repeat (3) tick();
    chk("midrst_count", obs_q.size(), 1);
    if (obs_q.size() == 1) begin
      chk("midrst_addr", obs_q[0].addr, 32'h040);
      chk("midrst_data", obs_q[0].data, 32'h44332211);
      chk("midrst_target", 32'(obs_q[0].dccm), 0);
    end

    // Randomized streams against the reference model.
    for (int it = 0; it < 25; it++) begin
      do_reset();
      stim_q.delete();
      nl = int'($urandom_range(1, 3));
      for (int l = 0; l < nl; l++) begin
        if ($urandom_range(0, 3) == 0) stim_q.push_back(8'($urandom_range(4, 255)));
        stim_q.push_back(8'($urandom_range(1, 2)));
        a16 = 16'($urandom);
        if ($urandom_range(0, 3) == 0) a16[10:0] = 11'h7FE;
        cnt = int'($urandom_range(0, 4));
        stim_q.push_back(a16[7:0]);
        stim_q.push_back(a16[15:8]);
        stim_q.push_back(8'(cnt));
        stim_q.push_back(8'h00);
        for (int k = 0; k < 4 * cnt; k++) stim_q.push_back(8'($urandom));
      end
      if ($urandom_range(0, 1) == 1) stim_q.push_back(8'h03);
      send_stream(2);
      model();
      compare_model();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
